// File: rtl/decode_stage_buffer_if.sv
// decode_stage_buffer_if: fetch->decode handshake bundle for decode_stage_buffer.
// The illegal_out signal exists only when ID_ILLEGAL_CHK_EN is defined.
interface decode_stage_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            halt;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instr_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instr_out;
    logic [CW-1:0]   count;
`ifdef ID_ILLEGAL_CHK_EN
    logic            illegal_out;
`endif

    // Buffer side
    modport slave (
        input  flush, halt, in_valid, pc_in, instr_in, out_ready,
        output in_ready, out_valid, pc_out, instr_out, count
`ifdef ID_ILLEGAL_CHK_EN
        , output illegal_out
`endif
    );

    // Fetch/decode side
    modport master (
        output flush, halt, in_valid, pc_in, instr_in, out_ready,
        input  in_ready, out_valid, pc_out, instr_out, count
`ifdef ID_ILLEGAL_CHK_EN
        , input illegal_out
`endif
    );
endinterface

// File: rtl/decode_stage_buffer.sv
// decode_stage_buffer: DEPTH-entry circular buffer between fetch and decode.
// One-cycle latency, no combinational in->out path, flush beats halt beats
// push/pop. Optional feature macro: ID_ILLEGAL_CHK_EN (per-entry illegal
// encoding flag presented on illegal_out).
module decode_stage_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decode_stage_buffer_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            in_ready, out_valid, push, pop;

    // Handshake qualification; reset holds the input side closed
    always_comb begin
        in_ready  = rst_n && (count_q != CW'(DEPTH)) && !bus.halt && !bus.flush;
        out_valid = (count_q != '0);
        push      = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready && !bus.halt && !bus.flush;
    end

    // Payload storage; never cleared, outputs are masked by out_valid instead
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.pc_in;
            instr_mem[wr_ptr] <= bus.instr_in;
        end
    end

    // Pointers and occupancy; flush returns everything to the empty state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head presentation, masked to 0/NOP when nothing is buffered
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.count     = count_q;
        bus.pc_out    = out_valid ? pc_mem[rd_ptr]    : '0;
        bus.instr_out = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    end

`ifdef ID_ILLEGAL_CHK_EN
    logic ill_mem [DEPTH];

    // Flag computed once at push so decode sees it with the entry
    always_ff @(posedge clk) begin
        if (push)
            ill_mem[wr_ptr] <= (bus.instr_in[1:0] != 2'b11) || (bus.instr_in == '0);
    end

    // Flag is only meaningful while an entry is presented
    always_comb begin
        bus.illegal_out = out_valid && ill_mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_decode_stage_buffer.sv
// tb_decode_stage_buffer: directed scenarios plus randomized traffic checked
// against a queue model of the buffer. Inputs driven at negedge, outputs
// sampled before the following posedge.
module tb_decode_stage_buffer;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t q[$];

    decode_stage_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_stage_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the queue model
    task automatic check_outputs(input string tag, input logic exp_rdy);
        logic [31:0] epc, eins;
        epc  = (q.size() != 0) ? q[0].pc    : 32'h0;
        eins = (q.size() != 0) ? q[0].instr : NOP;
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(exp_rdy));
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
        chk({tag, ".pc_out"},    64'(bus.pc_out),    64'(epc));
        chk({tag, ".instr_out"}, 64'(bus.instr_out), 64'(eins));
        chk({tag, ".count"},     64'(bus.count),     64'(q.size()));
`ifdef ID_ILLEGAL_CHK_EN
        chk({tag, ".illegal"}, 64'(bus.illegal_out),
            64'((q.size() != 0) && ((eins[1:0] != 2'b11) || (eins == 32'h0))));
`endif
    endtask

    // One clock: drive at negedge, check pre-edge state, update model at posedge
    task automatic cycle(input string tag, input logic fl, input logic ha, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        logic exp_rdy, do_push, do_pop;
        bus.flush = fl; bus.halt = ha; bus.in_valid = iv;
        bus.pc_in = pc; bus.instr_in = ins; bus.out_ready = ordy;
        #1;
        exp_rdy = (q.size() != DEPTH) && !ha && !fl;
        check_outputs(tag, exp_rdy);
        do_push = iv && exp_rdy;
        do_pop  = (q.size() != 0) && ordy && !ha && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{pc: pc, instr: ins});
        end
        @(negedge clk);
    endtask

    initial begin
        bus.flush = 0; bus.halt = 0; bus.in_valid = 0;
        bus.pc_in = '0; bus.instr_in = '0; bus.out_ready = 0;

        // Reset state
        #1;
        chk("rst.in_ready",  64'(bus.in_ready),  64'(0));
        chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst.instr_out", 64'(bus.instr_out), 64'(NOP));
        chk("rst.count",     64'(bus.count),     64'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single push, visible after one edge
        cycle("push1", 0, 0, 1, 32'h100, 32'h0050_0093, 0);
        cycle("hold1", 0, 0, 0, 32'h0,   32'h0,         0);
        cycle("fill",  0, 0, 1, 32'h104, 32'h0010_0113, 0);
        // Full: third offer refused, then accepted after the pop
        cycle("full0", 0, 0, 1, 32'h108, 32'h0020_0193, 0);
        cycle("full1", 0, 0, 1, 32'h108, 32'h0020_0193, 1);
        cycle("full2", 0, 0, 1, 32'h108, 32'h0020_0193, 0);
        // Flush with count=2 and an offered entry
        cycle("flush", 1, 0, 1, 32'h10c, 32'h0030_0213, 1);
        cycle("aflsh", 0, 0, 0, 32'h0,   32'h0,         0);

        // Streaming: one push and pop per cycle, count stays at 1
        cycle("strm0", 0, 0, 1, 32'h200, 32'h0000_0093, 1);
        for (int i = 1; i <= 10; i++)
            cycle("strm", 0, 0, 1, 32'h200 + 32'(4 * i), 32'h0000_0093 + 32'(i << 7), 1);

        // Halt for 3 cycles with traffic offered, then resume
        for (int i = 0; i < 3; i++)
            cycle("halt", 0, 1, 1, 32'h300, 32'h0000_0013, 1);
        cycle("resume", 0, 0, 1, 32'h304, 32'h0000_0000, 0);
        cycle("resum2", 0, 0, 1, 32'h308, 32'h0000_0013, 1);
        cycle("resum3", 0, 0, 0, 32'h0,   32'h0,         1);
        cycle("resum4", 0, 0, 0, 32'h0,   32'h0,         1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            case ($urandom_range(0, 7))
                0:       ins = 32'h0;
                1:       ins = NOP;
                default: ins = $urandom;
            endcase
            cycle("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, ins, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset mid-stream
        cycle("pre_rst", 0, 0, 1, 32'h400, 32'h0000_0000, 0);
        bus.in_valid = 1'b1; bus.pc_in = 32'h404; bus.instr_in = 32'h0000_0093;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check_outputs("async_rst", 1'b0);
        @(negedge clk);
        check_outputs("in_rst", 1'b0);
        rst_n = 1'b1;
        cycle("post_rst", 0, 0, 1, 32'h500, 32'h0000_0013, 0);
        cycle("post_rs2", 0, 0, 0, 32'h0,   32'h0,         1);
        cycle("post_rs3", 0, 0, 0, 32'h0,   32'h0,         0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
